clkinv_div_bank: RTL

- Parametrised multi-channel clock-output generator in the CLK domain; successor to the single fixed clock inverter.
- Each channel produces a registered, divided output ZN[c] with programmable divide ratio and output polarity.
- Per-channel run/stop control; divide ratio and polarity reprogrammed through a valid/ready config port.
- Changes apply only at period boundaries, so no runt pulses.
- Feeds clock-tree leaf drivers; never gates CLK combinationally.

---
 rtl/clkinv_div_pkg.sv | 15 +
 rtl/clkinv_div_chan.sv | 75 +++++++
 rtl/clkinv_div_bank.sv | 72 +++++++
 3 files changed

// File: rtl/clkinv_div_pkg.sv
// clkinv_div_pkg: shared sizing helper and pending-config record for clkinv_div_bank.
//   ch_w(n)  : width of a channel index for n channels (at least 1 bit)
//   cfg_t    : {ch, div, inv} config record, sized for the largest legal bank
package clkinv_div_pkg;
    localparam int CH_MAX_W  = 4;
    localparam int DIV_MAX_W = 16;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    typedef struct packed {
        logic [CH_MAX_W-1:0]  ch;
        logic [DIV_MAX_W-1:0] div;
        logic                 inv;
    } cfg_t;
endpackage

// File: rtl/clkinv_div_chan.sv
// clkinv_div_chan: one divided clock channel with run/stop and boundary-safe reconfiguration.
//   clk, rn     : clock, asynchronous active-low reset
//   en          : run request
//   sync        : force running channel back to phase 0 / count 0
//   apply       : load new_div/new_inv this edge
//   can_apply   : channel is idle, at a period boundary, or being synced
//   zn          : registered output, phase ^ inv
module clkinv_div_chan
    import clkinv_div_pkg::*;
#(
    parameter int   DIVW    = 4,
    parameter logic RST_INV = 1'b1
) (
    input  logic            clk,
    input  logic            rn,
    input  logic            en,
    input  logic            sync,
    input  logic            apply,
    input  logic [DIVW-1:0] new_div,
    input  logic            new_inv,
    output logic            can_apply,
    output logic            zn
);
    logic            run, phase, inv, run_n, phase_n, inv_n;
    logic [DIVW-1:0] cnt, div, cnt_n, div_n;
    logic            term;
    assign term      = cnt == div;
    assign can_apply = !run || (phase && term) || sync;
    always_comb begin
        run_n   = run;
        cnt_n   = cnt;
        phase_n = phase;
        div_n   = div;
        inv_n   = inv;
        if (!run)
            run_n = en;
        else if (sync) begin
            cnt_n   = '0;
            phase_n = 1'b0;
            run_n   = en;
        end else if (!phase && !en) begin
            run_n = 1'b0;
            cnt_n = '0;
        end else if (term) begin
            cnt_n   = '0;
            phase_n = !phase;
            // a stop requested during the high half takes effect only here
            run_n   = phase ? en : run;
        end else
            cnt_n = cnt + 1'b1;
        if (apply) begin
            div_n = new_div;
            inv_n = new_inv;
            cnt_n = '0;
        end
    end
    // zn is its own flop so the output never sees a combinational path
    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            run   <= 1'b0;
            cnt   <= '0;
            phase <= 1'b0;
            div   <= '0;
            inv   <= RST_INV;
            zn    <= RST_INV;
        end else begin
            run   <= run_n;
            cnt   <= cnt_n;
            phase <= phase_n;
            div   <= div_n;
            inv   <= inv_n;
            zn    <= phase_n ^ inv_n;
        end
    end
endmodule

// File: rtl/clkinv_div_bank.sv
// clkinv_div_bank: NCH-channel programmable clock divider/inverter bank with valid/ready config port.
//   CLK, RN            : clock, asynchronous active-low reset
//   EN[NCH]            : per-channel run request
//   CFG_VALID/READY    : config handshake; READY low while an update is pending
//   CFG_CH/DIV/INV     : target channel, half-period-minus-one, output polarity
//   CFG_DONE           : one-cycle pulse after a config is applied
//   ZN[NCH]            : registered channel clocks
//   SYNC               : only with CLKINV_DIV_SYNC_EN defined; realigns all running channels
//   VDD, VSS           : supply pins, no function
module clkinv_div_bank
    import clkinv_div_pkg::*;
#(
    parameter int   NCH     = 4,
    parameter int   DIVW    = 4,
    parameter logic RST_INV = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RN,
    input  logic [NCH-1:0]         EN,
    input  logic                   CFG_VALID,
    output logic                   CFG_READY,
    input  logic [ch_w(NCH)-1:0]   CFG_CH,
    input  logic [DIVW-1:0]        CFG_DIV,
    input  logic                   CFG_INV,
    output logic                   CFG_DONE,
    output logic [NCH-1:0]         ZN,
`ifdef CLKINV_DIV_SYNC_EN
    input  logic                   SYNC,
`endif
    inout  wire                    VDD,
    inout  wire                    VSS
);
    cfg_t           pend;
    logic           pend_v, sync, bad_ch;
    logic [NCH-1:0] can_apply, apply;
`ifdef CLKINV_DIV_SYNC_EN
    assign sync = SYNC;
`else
    assign sync = 1'b0;
`endif
    wire unused_ok = ^{VDD, VSS, pend.div};
    assign CFG_READY = !pend_v;
    assign bad_ch    = int'(pend.ch) >= NCH;
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign apply[c] = pend_v && int'(pend.ch) == c && can_apply[c];
        clkinv_div_chan #(.DIVW(DIVW), .RST_INV(RST_INV)) u_chan (
            .clk       (CLK),
            .rn        (RN),
            .en        (EN[c]),
            .sync      (sync),
            .apply     (apply[c]),
            .new_div   (pend.div[DIVW-1:0]),
            .new_inv   (pend.inv),
            .can_apply (can_apply[c]),
            .zn        (ZN[c])
        );
    end
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            pend_v   <= 1'b0;
            pend     <= '0;
            CFG_DONE <= 1'b0;
        end else begin
            CFG_DONE <= |apply;
            if (CFG_VALID && !pend_v) begin
                pend_v <= 1'b1;
                pend   <= '{ch: CH_MAX_W'(CFG_CH), div: DIV_MAX_W'(CFG_DIV), inv: CFG_INV};
            end else if (pend_v && (bad_ch || |apply))
                pend_v <= 1'b0;
        end
    end
endmodule
